// File: rtl/axi4bus_pkg.sv
// Shared AXI4Bus interconnect definitions.
// Provides the BRESP encodings, the default B payload width and order-queue
// depth, the master-index constants, the output-stage state type and a BRESP
// classification helper.
package axi4bus_pkg;

  localparam int RESP_W_DEF = 6;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } bresp_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Anything other than OKAY counts as a non-OKAY response, EXOKAY included.
  function automatic logic is_error_resp(input logic [1:0] resp);
    return (resp != OKAY);
  endfunction

endpackage

// File: rtl/b_order_fifo.sv
// Order queue: a DEPTH-entry, 1-bit-wide circular FIFO holding source-master
// indices in arrival order.
// Ports: CLK, RESETn (async, active-low), push/din (enqueue), pop (dequeue),
//        head (oldest entry), full, empty.
// A push while full and a pop while empty are both ignored. When a push and
// a pop happen together, both take effect and the count is unchanged.
module b_order_fifo
  import axi4bus_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage, the naturally wrapping pointers and the occupancy count.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/b_backward_fabric.sv
// B-channel (write response) router. It returns responses from the single
// downstream slave to one of two upstream masters.
// Source-master indices of completed W bursts are queued in arrival order.
// Each accepted B response is steered to the master at the queue head
// through a one-entry registered output stage.
// Ports: CLK, RESETn (async, active-low);
//        ORDER_SRC/ORDER_VALID/ORDER_READY - order push from the W fabric;
//        DATA/VALID/READY                  - B response from the slave;
//        DATA0/VALID0/READY0, DATA1/VALID1/READY1 - B response to the masters;
//        ERR_CNT - saturating non-OKAY count, present only when
//                  B_BACKWARD_ERR_COUNT_EN is defined.
// READY is the only output that depends combinationally on inputs (READY0/1).
module b_backward_fabric
  import axi4bus_pkg::*;
#(
  parameter int RESP_W = RESP_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              ORDER_SRC,
  input  logic              ORDER_VALID,
  output logic              ORDER_READY,
  input  logic [RESP_W-1:0] DATA,
  input  logic              VALID,
  output logic              READY,
  output logic [RESP_W-1:0] DATA0,
  output logic              VALID0,
  input  logic              READY0,
  output logic [RESP_W-1:0] DATA1,
  output logic              VALID1,
  input  logic              READY1
`ifdef B_BACKWARD_ERR_COUNT_EN
  ,
  output logic [7:0]        ERR_CNT
`endif
);

  out_state_e        out_state;
  logic              out_dst;
  logic [RESP_W-1:0] out_data;
  logic              out_valid;
  logic              out_fire;
  logic              accept;
  logic              q_head;
  logic              q_full;
  logic              q_empty;

  b_order_fifo #(
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .CLK    (CLK),
    .RESETn (RESETn),
    .push   (ORDER_VALID && ORDER_READY),
    .din    (ORDER_SRC),
    .pop    (accept),
    .head   (q_head),
    .full   (q_full),
    .empty  (q_empty)
  );

  // A full queue never takes a push, even when a pop happens the same cycle.
  assign ORDER_READY = !q_full;
  assign out_valid   = (out_state == OUT_FULL);
  assign out_fire    = out_valid && (out_dst ? READY1 : READY0);
  // A response is taken only when its destination is already known, and
  // the output stage is free or is draining in this cycle.
  assign READY       = !q_empty && (!out_valid || out_fire);
  assign accept      = VALID && READY;

  assign DATA0  = out_data;
  assign DATA1  = out_data;
  assign VALID0 = out_valid && (out_dst == M0);
  assign VALID1 = out_valid && (out_dst == M1);

  // Output stage: one registered response plus its destination master.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      out_state <= OUT_EMPTY;
      out_dst   <= M0;
      out_data  <= '0;
    end else begin
      case (out_state)
        OUT_EMPTY: begin
          if (accept) begin
            out_state <= OUT_FULL;
            out_dst   <= q_head;
            out_data  <= DATA;
          end else begin
            out_state <= OUT_EMPTY;
          end
        end
        OUT_FULL: begin
          if (accept) begin
            out_state <= OUT_FULL;
            out_dst   <= q_head;
            out_data  <= DATA;
          end else if (out_fire) begin
            out_state <= OUT_EMPTY;
          end else begin
            out_state <= OUT_FULL;
          end
        end
        default: begin
          out_state <= OUT_EMPTY;
        end
      endcase
    end
  end

`ifdef B_BACKWARD_ERR_COUNT_EN
  // Saturating count of accepted responses whose BRESP is not OKAY.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ERR_CNT <= 8'h00;
    end else if (accept && is_error_resp(DATA[1:0]) && (ERR_CNT != 8'hFF)) begin
      ERR_CNT <= ERR_CNT + 8'h01;
    end else begin
      ERR_CNT <= ERR_CNT;
    end
  end
`endif

endmodule

// File: tb/tb_b_backward_fabric.sv
// Directed self-checking bench for b_backward_fabric.
// Inputs change 1 time unit after the rising edge, and outputs are checked
// 1 time unit later, well away from the active edge.
// With B_BACKWARD_ERR_COUNT_EN defined, ERR_CNT is checked as well.
module tb_b_backward_fabric;

  localparam int RW = 6;

  logic          CLK;
  logic          RESETn;
  logic          ORDER_SRC;
  logic          ORDER_VALID;
  logic          ORDER_READY;
  logic [RW-1:0] DATA;
  logic          VALID;
  logic          READY;
  logic [RW-1:0] DATA0;
  logic          VALID0;
  logic          READY0;
  logic [RW-1:0] DATA1;
  logic          VALID1;
  logic          READY1;
`ifdef B_BACKWARD_ERR_COUNT_EN
  logic [7:0]    ERR_CNT;
`endif

  int checks = 0;
  int errors = 0;

  b_backward_fabric #(.RESP_W(RW), .DEPTH(4)) dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .ORDER_SRC   (ORDER_SRC),
    .ORDER_VALID (ORDER_VALID),
    .ORDER_READY (ORDER_READY),
    .DATA        (DATA),
    .VALID       (VALID),
    .READY       (READY),
    .DATA0       (DATA0),
    .VALID0      (VALID0),
    .READY0      (READY0),
    .DATA1       (DATA1),
    .VALID1      (VALID1),
    .READY1      (READY1)
`ifdef B_BACKWARD_ERR_COUNT_EN
    ,
    .ERR_CNT     (ERR_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [RW-1:0] resp(input int k);
    logic [3:0] id;
    id = 4'(k + 1);
    return {id, 2'b00};
  endfunction

  initial begin
    logic exp_dst;
    RESETn      = 1'b0;
    ORDER_SRC   = 1'b0;
    ORDER_VALID = 1'b0;
    DATA        = '0;
    VALID       = 1'b0;
    READY0      = 1'b1;
    READY1      = 1'b1;

    // Reset state, first while reset is held and then after release.
    #12;
    check("rst_oready", 32'(ORDER_READY), 32'd1);
    check("rst_ready",  32'(READY),       32'd0);
    check("rst_valid",  32'({VALID1, VALID0}), 32'd0);
    check("rst_data",   32'({DATA1, DATA0}),   32'd0);
`ifdef B_BACKWARD_ERR_COUNT_EN
    check("rst_errcnt", 32'(ERR_CNT), 32'd0);
`endif
    @(posedge CLK);
    #1 RESETn = 1'b1;
    tick();
    check("idle_oready", 32'(ORDER_READY), 32'd1);
    check("idle_ready",  32'(READY),       32'd0);
    check("idle_valid",  32'({VALID1, VALID0}), 32'd0);

    // Orders 0,1,1, then three responses routed in that order.
    ORDER_VALID = 1'b1; ORDER_SRC = 1'b0; tick();
    ORDER_SRC = 1'b1; tick();
    tick();
    ORDER_VALID = 1'b0;
    VALID = 1'b1; DATA = 6'h04; #1;
    check("b3_ready", 32'(READY), 32'd1);
    tick();
    DATA = 6'h08; #1;
    check("b3_v0_a", 32'(VALID0), 32'd1);
    check("b3_d0_a", 32'(DATA0),  32'h04);
    check("b3_v1_a", 32'(VALID1), 32'd0);
    tick();
    DATA = 6'h0C; #1;
    check("b3_v1_b", 32'(VALID1), 32'd1);
    check("b3_d1_b", 32'(DATA1),  32'h08);
    check("b3_v0_b", 32'(VALID0), 32'd0);
    tick();
    VALID = 1'b0; #1;
    check("b3_v1_c", 32'(VALID1), 32'd1);
    check("b3_d1_c", 32'(DATA1),  32'h0C);
    check("b3_ready_empty", 32'(READY), 32'd0);
    tick();
    check("b3_drained", 32'({VALID1, VALID0}), 32'd0);

    // A response waits with no order queued, then one order releases it.
    VALID = 1'b1; DATA = 6'h1E;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("stall_ready", 32'(READY), 32'd0);
      check("stall_valid", 32'({VALID1, VALID0}), 32'd0);
      tick();
    end
    ORDER_VALID = 1'b1; ORDER_SRC = 1'b1; #1;
    check("stall_push_ready", 32'(READY), 32'd0);
    tick();
    ORDER_VALID = 1'b0; #1;
    check("stall_after_push", 32'(READY), 32'd1);
    check("stall_no_v1_yet",  32'(VALID1), 32'd0);
    tick();
    VALID = 1'b0; #1;
    check("stall_v1",  32'(VALID1), 32'd1);
    check("stall_d1",  32'(DATA1),  32'h1E);
    check("stall_v0",  32'(VALID0), 32'd0);
    tick();
    check("stall_drained", 32'(VALID1), 32'd0);

    // Fill the queue, push at full while popping, then wrap with 8 orders.
    ORDER_VALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ORDER_SRC = 1'(i);
      tick();
    end
    check("full_oready", 32'(ORDER_READY), 32'd0);
    ORDER_SRC = 1'b0; VALID = 1'b1; DATA = resp(0); #1;
    check("full_push_blocked", 32'(ORDER_READY), 32'd0);
    check("full_pop_ready",    32'(READY),       32'd1);
    tick();
    for (int k = 1; k <= 7; k++) begin
      ORDER_VALID = (k <= 4);
      ORDER_SRC   = 1'(k + 3);
      DATA        = resp(k);
      #1;
      exp_dst = 1'(k - 1);
      check("wrap_oready", 32'(ORDER_READY), 32'd1);
      check("wrap_ready",  32'(READY),       32'd1);
      check("wrap_v0",     32'(VALID0),      32'(!exp_dst));
      check("wrap_v1",     32'(VALID1),      32'(exp_dst));
      check("wrap_data",   32'(exp_dst ? DATA1 : DATA0), 32'(resp(k - 1)));
      tick();
    end
    VALID = 1'b0; ORDER_VALID = 1'b0; #1;
    check("wrap_last_v1", 32'(VALID1), 32'd1);
    check("wrap_last_d1", 32'(DATA1),  32'(resp(7)));
    check("wrap_empty_ready", 32'(READY), 32'd0);
    tick();
    check("wrap_drained", 32'({VALID1, VALID0}), 32'd0);

    // Master 0 backpressure holds the output stable and stalls the slave.
    READY0 = 1'b0;
    ORDER_VALID = 1'b1; ORDER_SRC = 1'b0; tick();
    tick();
    ORDER_VALID = 1'b0;
    VALID = 1'b1; DATA = 6'h14; tick();
    DATA = 6'h18;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_v0",    32'(VALID0), 32'd1);
      check("bp_d0",    32'(DATA0),  32'h14);
      check("bp_v1",    32'(VALID1), 32'd0);
      check("bp_ready", 32'(READY),  32'd0);
      tick();
    end
    READY0 = 1'b1; #1;
    check("bp_release_ready", 32'(READY), 32'd1);
    tick();
    VALID = 1'b0; #1;
    check("bp_next_v0", 32'(VALID0), 32'd1);
    check("bp_next_d0", 32'(DATA0),  32'h18);
    tick();
    check("bp_drained", 32'(VALID0), 32'd0);

`ifdef B_BACKWARD_ERR_COUNT_EN
    // Only the single SLVERR response so far has counted; then saturate.
    check("err_before", 32'(ERR_CNT), 32'd1);
    ORDER_VALID = 1'b1; ORDER_SRC = 1'b0;
    VALID = 1'b1; DATA = 6'h02;
    repeat (310) tick();
    check("err_sat", 32'(ERR_CNT), 32'hFF);
    DATA = 6'h00;
    repeat (5) tick();
    check("err_okay_hold", 32'(ERR_CNT), 32'hFF);
    ORDER_VALID = 1'b0; VALID = 1'b0;
    repeat (8) tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b_backward_fabric.md
# b_backward_fabric

Write-response (B channel) router for the AXI4Bus interconnect. It returns responses from the single downstream slave port to one of two upstream masters. It is the return-path counterpart of the 2:1 write-data forward fabric. The forward fabric reports the source master of every completed write burst, and this block queues those indices in arrival order. Each incoming B response is steered to the master at the head of the queue, through a one-entry registered output stage.

## Interface
Parameters:
- RESP_W, default 6: B payload width, packed as {BID[RESP_W-1:2], BRESP[1:0]}
- DEPTH, default 4: order-queue entries; power of two, ≥2

Ports:
- CLK  in  1  clock
- RESETn  in  1  reset, asynchronous, active-low
- ORDER_SRC  in  1  source master (0/1) of a completed W burst
- ORDER_VALID  in  1  ORDER_SRC valid
- ORDER_READY  out  1  order queue can accept
- DATA  in  RESP_W  response payload from slave
- VALID  in  1  slave response valid
- READY  out  1  response accepted
- DATA0  out  RESP_W  payload to master 0
- VALID0  out  1  response valid to master 0
- READY0  in  1  master 0 ready
- DATA1  out  RESP_W  payload to master 1
- VALID1  out  1  response valid to master 1
- READY1  in  1  master 1 ready
- ERR_CNT  out  8  non-OKAY response count; present only with macro

## Operation
- Order queue: DEPTH-entry circular FIFO.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally; the count is log2(DEPTH)+1 bits.
  - Push when ORDER_VALID && ORDER_READY.
  - ORDER_READY = (count != DEPTH). There is no pass-through when full, even if a pop occurs the same cycle.
- Output stage has two states, EMPTY and FULL, held as out_valid plus a 1-bit destination out_dst.
- Output firing:
  - out_fire = out_valid && (out_dst ? READY1 : READY0).
  - READY = (count != 0) && (!out_valid || out_fire).
- Accept = VALID && READY. On accept:
  - DATA is registered into the output stage.
  - out_dst is loaded from the queue head.
  - The queue pops.
  - The state becomes or stays FULL.
- out_fire without accept → EMPTY.
- Steering of the registered payload:
  - DATA0 and DATA1 both carry the registered payload.
  - VALID0 = out_valid && !out_dst.
  - VALID1 = out_valid && out_dst.
  - The non-selected master never sees VALID.
- Empty queue: READY=0. The slave response stalls indefinitely; no data is dropped or misrouted.
- Simultaneous push and pop: both take effect and the count is unchanged. This is legal at full (pop only, push blocked) and at empty (push only, pop impossible).
- Once VALIDx is asserted, payload and destination stay stable until the corresponding READYx is seen.
- Reset mid-operation discards queued orders and any pending response immediately (asynchronous).

## Timing
- Reset values:
  - ORDER_READY=1, READY=0.
  - VALID0=VALID1=0, DATA0=DATA1=0.
  - ERR_CNT=0.
  - Queue empty; out state EMPTY.
- Order push to READY visible: 1 cycle. A push at cycle N gives READY=1 at N+1 when the output stage is free.
- Response latency: accept at edge N → VALIDx high from N+1.
- Throughput: 1 response/cycle with READYx held high (back-to-back via out_fire).
- READY is combinational on READY0/READY1. No other combinational input→output path exists.

## Configuration
- B_BACKWARD_ERR_COUNT_EN defined:
  - ERR_CNT port exists.
  - Increments by 1 on each accept with DATA[1:0] != OKAY.
  - Saturates at 8'hFF.
- Undefined: ERR_CNT port and counter are absent. Routing behaviour is identical either way.

## Structure
- Shared package axi4bus_pkg:
  - BRESP encodings OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Default RESP_W and DEPTH constants.
  - Master-index constants M0=1'b0, M1=1'b1.
- Sub-module b_order_fifo, parameterised by DEPTH with 1-bit width:
  - push, pop, head, full and empty outputs.
  - Instantiated once.
- Top level holds the output stage, steering and the optional error counter.

## Test plan
- Reset, then idle → ORDER_READY=1, READY=0, VALID0=VALID1=0, DATA0=DATA1=0.
- Push orders 0,1,1 then three responses 6'h04, 6'h08, 6'h0C, with READY0/READY1=1:
  - Master 0 gets 6'h04.
  - Master 1 gets 6'h08, then 6'h0C.
  - Each appears 1 cycle after accept.
- Response held VALID with empty queue for 10 cycles → READY=0 throughout. Push order 1 → accept on the following cycle; VALID1=1 the cycle after.
- Fill 4 orders → ORDER_READY=0. Push while popping at full → push blocked, count 4→3. The wrap-around sequence of 8 alternating orders routes in exact order.
- Order 0 with READY0=0 for 5 cycles → VALID0 stays high with DATA0 stable, VALID1 never asserts. The second response is not accepted until READY0 rises, then flows back-to-back.
- With B_BACKWARD_ERR_COUNT_EN, 300 SLVERR responses → ERR_CNT saturates at 8'hFF. OKAY responses leave ERR_CNT unchanged.
